// File: rtl/sub_bytes_engine_if.sv
// Handshake bundle between the round datapath and the SubBytes engine.
// The master drives the state in and takes the result; the slave is the engine.
interface sub_bytes_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_mode, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_mode, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes / InvSubBytes engine: a 128-bit state is substituted in
// place, LANES bytes per cycle, then held until the downstream stage accepts it.
module sub_bytes_engine #(
    parameter int LANES  = 16,
    parameter bit INV_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    sub_bytes_engine_if.slave bus
);

    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES=%0d does not divide the 16-byte state", LANES);
    end

    // One 128-bit literal per table row; row/column 0 land in the MSBs, so lookups
    // use the inverted nibbles as packed indices.
    localparam logic [15:0][15:0][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [15:0][15:0][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        if (INV_EN && inv) return SBOX_INV[~b[7:4]][~b[3:0]];
        return SBOX_FWD[~b[7:4]][~b[3:0]];
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [127:0]     r_work, w_work_nxt, w_work_sub;
    logic             r_mode, w_mode_nxt;
    logic             w_in_ready, w_out_valid, w_busy;
    logic             w_last_beat;

    // Byte k of the state sits at [127-8k -: 8]; this beat covers bytes cnt*LANES upward.
    always_comb begin
        w_work_sub = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_sub[127 - 8*(int'(r_cnt)*LANES + l) -: 8] =
                sub_byte(r_work[127 - 8*(int'(r_cnt)*LANES + l) -: 8], r_mode);
        end
    end

    assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_work_nxt  = r_work;
        w_mode_nxt  = r_mode;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_work_nxt  = bus.in_state;
                    w_mode_nxt  = INV_EN & bus.in_mode;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy     = 1'b1;
                w_work_nxt = w_work_sub;
                if (w_last_beat) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the work register is cleared on
    // reset too, so an aborted state can never surface later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_work  <= w_work_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_state = w_out_valid ? r_work : '0;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine: three builds (16 lanes, 1 lane, 2 lanes
// forward-only) checked against a GF(2^8)-derived S-box model and hand vectors.
module tb_sub_bytes_engine;

    localparam int NDUT = 3;
    localparam int CFG_LANES [NDUT] = '{16, 1, 2};
    localparam bit CFG_INV   [NDUT] = '{1'b1, 1'b1, 1'b0};

    localparam logic [127:0] T1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] T1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         drv_reset     [NDUT];
    logic         drv_valid     [NDUT];
    logic         drv_mode      [NDUT];
    logic [127:0] drv_state     [NDUT];
    logic         drv_out_ready [NDUT];
    logic         obs_in_ready  [NDUT];
    logic         obs_out_valid [NDUT];
    logic         obs_busy      [NDUT];
    logic [127:0] obs_out_state [NDUT];

    int n_vec = 0;
    int n_bad = 0;

    logic [127:0] exp_q0 [$];
    logic [127:0] exp_q1 [$];
    logic [127:0] exp_q2 [$];

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_engine_if bus ();

        assign bus.in_valid     = drv_valid[g];
        assign bus.in_mode      = drv_mode[g];
        assign bus.in_state     = drv_state[g];
        assign bus.out_ready    = drv_out_ready[g];
        assign obs_in_ready[g]  = bus.in_ready;
        assign obs_out_valid[g] = bus.out_valid;
        assign obs_busy[g]      = bus.busy;
        assign obs_out_state[g] = bus.out_state;

        sub_bytes_engine #(.LANES(CFG_LANES[g]), .INV_EN(CFG_INV[g])) u_dut (
            .clk   (clk),
            .reset (drv_reset[g]),
            .bus   (bus)
        );
    end

    // S-box model: multiplicative inverse in GF(2^8) followed by the AES affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[127-8*k -: 8] = inv ? inv_tab[st[127-8*k -: 8]] : fwd_tab[st[127-8*k -: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic push_exp(input int idx, input logic [127:0] v);
        case (idx)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [127:0] q_pop(input int idx);
        case (idx)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    // Monitor: every output handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!drv_reset[i] && obs_out_valid[i] && drv_out_ready[i]) begin
                if (q_size(i) == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_out[%0d]: got %h want no output", i, obs_out_state[i]);
                end else begin
                    check($sformatf("out_state[%0d]", i), obs_out_state[i], q_pop(i));
                end
            end
        end
    end

    task automatic send(input int idx, input logic [127:0] st, input logic md,
                        input logic [127:0] want, input bit track);
        bit taken;
        taken = 1'b0;
        drv_state[idx] = st;
        drv_mode[idx]  = md;
        drv_valid[idx] = 1'b1;
        for (int t = 0; t < 200 && !taken; t++) begin
            @(negedge clk);
            if (obs_in_ready[idx]) begin
                if (track) push_exp(idx, want);
                @(posedge clk);
                #1;
                taken = 1'b1;
            end
        end
        drv_valid[idx] = 1'b0;
        drv_state[idx] = ~st;
        drv_mode[idx]  = ~md;
        if (!taken) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout[%0d]: got in_ready low want in_ready within 200 cycles", idx);
        end
    endtask

    task automatic wait_valid(input int idx, input int want_cycles, input string name);
        int n;
        n = 0;
        while (!obs_out_valid[idx] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 128'(n), 128'(want_cycles));
    endtask

    task automatic wait_drain(input int idx);
        int n;
        n = 0;
        while ((q_size(idx) != 0 || !obs_in_ready[idx]) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_bit($sformatf("drain[%0d]", idx), q_size(idx) == 0 && obs_in_ready[idx], 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want completion within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            drv_reset[i]     = 1'b1;
            drv_valid[i]     = 1'b0;
            drv_mode[i]      = 1'b0;
            drv_state[i]     = '0;
            drv_out_ready[i] = 1'b1;
        end
        for (int i = 0; i < 256; i++) fwd_tab[i] = ref_sbox(i[7:0]);
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = i[7:0];

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check_bit($sformatf("rst_in_ready[%0d]", i), obs_in_ready[i], 1'b1);
            check_bit($sformatf("rst_out_valid[%0d]", i), obs_out_valid[i], 1'b0);
            check_bit($sformatf("rst_busy[%0d]", i), obs_busy[i], 1'b0);
            check($sformatf("rst_out_state[%0d]", i), obs_out_state[i], '0);
            drv_reset[i] = 1'b0;
        end

        // T1: forward, 16 lanes, one-cycle latency
        send(0, T1_IN, 1'b0, T1_OUT, 1'b1);
        check_bit("t1_busy", obs_busy[0], 1'b1);
        check_bit("t1_in_ready", obs_in_ready[0], 1'b0);
        wait_valid(0, 1, "t1_latency");
        wait_drain(0);

        // T2: inverse, and the forward-only build ignoring in_mode
        send(0, T1_OUT, 1'b1, T1_IN, 1'b1);
        wait_drain(0);
        send(2, T1_OUT, 1'b1, ref_state(T1_OUT, 1'b0), 1'b1);
        wait_valid(2, 8, "t2_noinv_latency");
        wait_drain(2);

        // T3: single lane, 16 RUN cycles, in_valid pulses ignored
        send(1, '0, 1'b0, {16{8'h63}}, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            check_bit($sformatf("t3_in_ready_c%0d", c), obs_in_ready[1], 1'b0);
            check_bit($sformatf("t3_busy_c%0d", c), obs_busy[1], 1'b1);
            check_bit($sformatf("t3_out_valid_c%0d", c), obs_out_valid[1], 1'b0);
            drv_state[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
            drv_mode[1]  = 1'b1;
            drv_valid[1] = 1'b1;
            @(posedge clk);
            #1;
        end
        drv_valid[1] = 1'b0;
        check_bit("t3_out_valid_after_16", obs_out_valid[1], 1'b1);
        wait_drain(1);
        send(1, T1_IN, 1'b0, T1_OUT, 1'b1);
        wait_drain(1);

        // T4: backpressure holds the result; a DONE-cycle in_valid is not taken
        drv_out_ready[0] = 1'b0;
        send(0, T1_IN, 1'b0, T1_OUT, 1'b1);
        wait_valid(0, 1, "t4_latency");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_bit($sformatf("t4_hold_valid_c%0d", c), obs_out_valid[0], 1'b1);
            check($sformatf("t4_hold_state_c%0d", c), obs_out_state[0], T1_OUT);
        end
        drv_out_ready[0] = 1'b1;
        drv_state[0]     = {16{8'hc3}};
        drv_valid[0]     = 1'b1;
        @(posedge clk);
        #1;
        drv_valid[0] = 1'b0;
        check_bit("t4_release_in_ready", obs_in_ready[0], 1'b1);
        check_bit("t4_release_busy", obs_busy[0], 1'b0);
        check_bit("t4_release_out_valid", obs_out_valid[0], 1'b0);
        check("t4_release_out_state", obs_out_state[0], '0);

        // T5: reset in the third RUN cycle of the 2-lane build
        send(2, {16{8'h5a}}, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_bit("t5_busy_before_reset", obs_busy[2], 1'b1);
        drv_reset[2] = 1'b1;
        @(posedge clk);
        #1;
        drv_reset[2] = 1'b0;
        check_bit("t5_in_ready", obs_in_ready[2], 1'b1);
        check_bit("t5_busy", obs_busy[2], 1'b0);
        check_bit("t5_out_valid", obs_out_valid[2], 1'b0);
        check("t5_out_state", obs_out_state[2], '0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check_bit("t5_no_late_output", obs_out_valid[2], 1'b0);
        send(2, T1_IN, 1'b0, T1_OUT, 1'b1);
        wait_valid(2, 8, "t5_fresh_latency");
        wait_drain(2);

        // T6: spot values, then every byte value round-tripped on each build
        send(0, {16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
        send(0, {16{8'h63}}, 1'b1, '0, 1'b1);
        wait_drain(0);
        fork
            begin
                for (int v = 0; v < 256; v++) begin
                    send(0, {16{v[7:0]}}, 1'b0, {16{fwd_tab[v]}}, 1'b1);
                    send(0, {16{fwd_tab[v]}}, 1'b1, {16{v[7:0]}}, 1'b1);
                end
            end
            begin
                for (int v = 0; v < 256; v++) begin
                    send(1, {16{v[7:0]}}, 1'b0, {16{fwd_tab[v]}}, 1'b1);
                    send(1, {16{fwd_tab[v]}}, 1'b1, {16{v[7:0]}}, 1'b1);
                end
            end
            begin
                for (int v = 0; v < 256; v++)
                    send(2, {16{v[7:0]}}, 1'b1, {16{fwd_tab[v]}}, 1'b1);
            end
        join
        for (int i = 0; i < NDUT; i++) wait_drain(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
